// File: rtl/sq_wave_period_meas.sv
// Square-wave period meter: measures ON/OFF phase lengths in TICK_DIV-cycle ticks
// and reports each complete {ON, OFF} pair with overflow/inexact flags.
module sq_wave_period_meas #(
  parameter int W           = 4,
  parameter int TICK_DIV    = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         sq_wave,
  output logic [W-1:0] meas_on,
  output logic [W-1:0] meas_off,
  output logic         meas_valid,
  output logic         meas_ovf,
  output logic         meas_inexact,
  output logic         debug_tick
);
  localparam int          CW   = $clog2(TICK_DIV + 1);
  localparam logic [W-1:0] TMAX = '1;

  typedef enum logic [1:0] {WAIT_EDGE, MEAS_HIGH, MEAS_LOW} state_t;

  state_t                 state, state_n;
  logic [SYNC_STAGES-1:0] sync;
  logic [SYNC_STAGES:0]   primed;
  logic                   s, s_q, edge_det, rise, fall;
  logic [CW-1:0]          cyc;
  logic [W-1:0]           ticks, on_ticks;
  logic                   sat, on_sat, on_inexact, have_on;
  logic                   latch_on, report, inexact;

  // Edges are ignored until the chain holds real post-reset samples, so a
  // high input at reset release is not mistaken for a rising edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync   <= '0;
      s_q    <= 1'b0;
      primed <= '0;
    end else begin
      sync   <= (sync << 1) | SYNC_STAGES'(sq_wave);
      s_q    <= s;
      primed <= {primed[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign s        = sync[SYNC_STAGES-1];
  assign edge_det = primed[SYNC_STAGES] & (s ^ s_q);
  assign rise     = edge_det & s;
  assign fall     = edge_det & ~s;
  assign inexact  = (cyc != '0);

  // An edge takes priority over a tick wrap in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cyc        <= '0;
      ticks      <= '0;
      sat        <= 1'b0;
      debug_tick <= 1'b0;
    end else if (edge_det) begin
      cyc        <= CW'(1);
      ticks      <= '0;
      sat        <= 1'b0;
      debug_tick <= 1'b0;
    end else if (cyc == CW'(TICK_DIV - 1)) begin
      cyc        <= '0;
      debug_tick <= 1'b1;
      if (ticks == TMAX) sat <= 1'b1;
      else               ticks <= ticks + W'(1);
    end else begin
      cyc        <= cyc + CW'(1);
      debug_tick <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= WAIT_EDGE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      WAIT_EDGE: if (rise) state_n = MEAS_HIGH;
                 else if (fall) state_n = MEAS_LOW;
      MEAS_HIGH: if (fall) state_n = MEAS_LOW;
      MEAS_LOW:  if (rise) state_n = MEAS_HIGH;
      default:   state_n = WAIT_EDGE;
    endcase
  end

  always_comb begin
    latch_on = (state == MEAS_HIGH) & fall;
    report   = (state == MEAS_LOW) & rise & have_on;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      on_ticks     <= '0;
      on_sat       <= 1'b0;
      on_inexact   <= 1'b0;
      have_on      <= 1'b0;
      meas_on      <= '0;
      meas_off     <= '0;
      meas_valid   <= 1'b0;
      meas_ovf     <= 1'b0;
      meas_inexact <= 1'b0;
    end else begin
      meas_valid <= report;
      if (latch_on) begin
        on_ticks   <= ticks;
        on_sat     <= sat;
        on_inexact <= inexact;
        have_on    <= 1'b1;
      end
      if (report) begin
        meas_on      <= on_ticks;
        meas_off     <= ticks;
        meas_ovf     <= on_sat | sat;
        meas_inexact <= on_inexact | inexact;
      end
    end
  end
endmodule

// File: tb/tb_sq_wave_period_meas.sv
// Bench for sq_wave_period_meas: event-level reference model of phase lengths
// compared every cycle, plus literal checks on the directed scenarios.
module tb_sq_wave_period_meas;
  localparam int W = 4, TD = 10, SS = 2;
  localparam int MAXT = (1 << W) - 1;

  logic         clk = 1'b0, reset = 1'b0, sq_wave = 1'b0;
  logic [W-1:0] meas_on, meas_off;
  logic         meas_valid, meas_ovf, meas_inexact, debug_tick;

  sq_wave_period_meas #(.W(W), .TICK_DIV(TD), .SYNC_STAGES(SS)) dut (
    .clk(clk), .reset(reset), .sq_wave(sq_wave),
    .meas_on(meas_on), .meas_off(meas_off), .meas_valid(meas_valid),
    .meas_ovf(meas_ovf), .meas_inexact(meas_inexact), .debug_tick(debug_tick)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d @%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: works on the sampled transition times of sq_wave.
  typedef struct {int due; bit kind; int on; int off; bit ovf; bit inex;} ev_t;
  ev_t q[$];
  int  n = 0, r = 0, tprev = 0, base = 0;
  bit  have_prev, have_on, last_v, model_ok = 0;
  int  on_t;
  bit  on_s, on_i;
  int  e_on, e_off;
  bit  e_valid, e_ovf, e_inex, e_dbg;

  always @(posedge clk) begin
    n++;
    if (!reset) begin
      r = n; base = n; have_prev = 0; have_on = 0; q.delete();
      e_on = 0; e_off = 0; e_valid = 0; e_ovf = 0; e_inex = 0; e_dbg = 0;
    end else begin
      bit rep_hit, base_hit;
      ev_t rep;
      if (n >= r + 2 && sq_wave != last_v) begin
        ev_t ev;
        int  L, tk;
        bit  st, inx;
        ev.due = n + SS - 1; ev.kind = 0; ev.on = 0; ev.off = 0; ev.ovf = 0; ev.inex = 0;
        q.push_back(ev);
        if (have_prev) begin
          L = n - tprev; tk = L / TD; st = tk > MAXT; inx = (L % TD) != 0;
          if (st) tk = MAXT;
          if (!sq_wave) begin
            on_t = tk; on_s = st; on_i = inx; have_on = 1;
          end else if (have_on) begin
            ev.due = n + SS; ev.kind = 1; ev.on = on_t; ev.off = tk;
            ev.ovf = on_s | st; ev.inex = on_i | inx;
            q.push_back(ev);
          end
        end
        have_prev = 1; tprev = n;
      end
      rep_hit = 0; base_hit = 0; rep = '{0, 0, 0, 0, 0, 0};
      while (q.size() > 0 && q[0].due == n) begin
        if (q[0].kind) begin rep_hit = 1; rep = q[0]; end
        else base_hit = 1;
        void'(q.pop_front());
      end
      e_valid = rep_hit;
      if (rep_hit) begin
        e_on = rep.on; e_off = rep.off; e_ovf = rep.ovf; e_inex = rep.inex;
      end
      e_dbg = (n > base) && ((n - base) % TD == 0);
      if (base_hit) base = n;
    end
    last_v = sq_wave;
    model_ok = 1;
  end

  int valid_cnt = 0;
  always @(negedge clk) begin
    if (model_ok) begin
      chk("meas_valid", meas_valid, e_valid);
      chk("debug_tick", debug_tick, e_dbg);
      chk("meas_on", meas_on, e_on);
      chk("meas_off", meas_off, e_off);
      chk("meas_ovf", meas_ovf, e_ovf);
      chk("meas_inexact", meas_inexact, e_inex);
      if (meas_valid) valid_cnt++;
    end
  end

  task automatic hold(input logic lvl, input int cyc);
    sq_wave = lvl;
    repeat (cyc) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic lit(input string nm, input int on, input int off, input int ovf, input int inex);
    chk({nm, "_on"}, meas_on, on);
    chk({nm, "_off"}, meas_off, off);
    chk({nm, "_ovf"}, meas_ovf, ovf);
    chk({nm, "_inexact"}, meas_inexact, inex);
  endtask

  initial begin
    int vc;
    repeat (3) @(posedge clk);
    #1;
    lit("reset", 0, 0, 0, 0);
    reset = 1'b1;

    // 100 ns high / 300 ns low
    repeat (5) begin hold(1, 10); hold(0, 30); end
    hold(1, 5);
    lit("loopback", 1, 3, 0, 0);

    // saturating ON phase, then a normal one
    hold(1, 155); hold(0, 20); hold(1, 5);
    lit("sat", 15, 2, 1, 0);
    hold(1, 15); hold(0, 50); hold(1, 5);
    lit("post_sat", 2, 5, 0, 0);

    // non-integral phases
    hold(1, 6); hold(0, 30); hold(1, 3);
    lit("inexact1", 1, 3, 0, 1);
    hold(0, 10); hold(1, 5);
    lit("inexact2", 0, 1, 0, 1);

    // reset while input is high mid-phase
    do_reset();
    lit("rst_high", 0, 0, 0, 0);
    vc = valid_cnt;
    hold(1, 7); hold(0, 20); hold(1, 30); hold(0, 10);
    chk("no_early_valid", valid_cnt - vc, 0);
    hold(1, 5);
    lit("first_after_rst", 3, 1, 0, 0);

    // reset mid low phase
    hold(1, 5); hold(0, 12);
    do_reset();
    lit("rst_low", 0, 0, 0, 0);
    hold(0, 8); hold(1, 20); hold(0, 40); hold(1, 5);
    lit("after_rst_low", 2, 4, 0, 0);

    // constant input for 5 us
    vc = valid_cnt;
    hold(1, 495);
    chk("const_no_valid", valid_cnt - vc, 0);
    lit("const_hold", 2, 4, 0, 0);

    // randomized phases, including back-to-back edges and saturating phases
    for (int i = 0; i < 40; i++) begin
      hold(0, ($urandom_range(0, 7) == 0) ? $urandom_range(150, 180) : $urandom_range(1, 45));
      hold(1, ($urandom_range(0, 7) == 0) ? $urandom_range(150, 180) : $urandom_range(1, 45));
    end
    hold(0, 1); hold(1, 1); hold(0, 1); hold(1, 20);
    lit("b2b", 0, 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
